// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding, default target address and rw encoding
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_NACK,
    ST_STOP
  } i2c_state_e;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'b1010101;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [1:0] Q_SAMPLE = 2'd2;
  localparam logic [1:0] Q_LAST   = 2'd3;

endpackage

// File: rtl/i2c_clk_div.sv
// rtl/i2c_clk_div.sv - SCL quarter-period tick generator with 2-bit quarter index
module i2c_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic       tick_o,
  output logic [1:0] quarter_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [1:0] qtr_q, qtr_d;

  assign tick_o    = en_i && (cnt_q == 8'(CLK_DIV - 1));
  assign quarter_o = qtr_q;

  // Held at zero while disabled so every transaction starts on a clean Q0.
  always_comb begin
    cnt_d = cnt_q;
    qtr_d = qtr_q;
    if (!en_i) begin
      cnt_d = '0;
      qtr_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      qtr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C master (write or read) to a fixed target address
// Define I2C_MASTER_ACK_CHECK_EN to branch straight to STOP after a slave NACK.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [6:0]  SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] data_write_master,
  output logic [7:0] data_read_master,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  inout  wire        scl,
  inout  wire        sda
);

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack_error_q, ack_error_d;
  logic       done_q, done_d;

  logic       tick;
  logic [1:0] quarter;
  logic       bit_end, sample, sda_in;
  logic       scl_drv, sda_low;
  logic [7:0] addr_byte;

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (state_q != ST_IDLE),
    .tick_o    (tick),
    .quarter_o (quarter)
  );

  assign bit_end   = tick && (quarter == Q_LAST);
  assign sample    = tick && (quarter == Q_SAMPLE);
  assign sda_in    = sda;
  assign addr_byte = {SLAVE_ADDR, rw_q};

  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign ack_error        = ack_error_q;
  assign data_read_master = rdata_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    ack_error_d = ack_error_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_START;
          rw_d        = rw;
          wdata_d     = data_write_master;
          ack_error_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_ADDR;
          bit_cnt_d = 3'd7;
        end
      end
      ST_ADDR: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd0) state_d = ST_ADDR_ACK;
          else                   bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      ST_ADDR_ACK: begin
        if (sample && sda_in) ack_error_d = 1'b1;
        if (bit_end) begin
          bit_cnt_d = 3'd7;
          state_d   = (rw_q == RW_READ) ? ST_READ : ST_WRITE;
`ifdef I2C_MASTER_ACK_CHECK_EN
          if (ack_error_q) state_d = ST_STOP;
`endif
        end
      end
      ST_WRITE: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd0) state_d = ST_WRITE_ACK;
          else                   bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      ST_WRITE_ACK: begin
        if (sample && sda_in) ack_error_d = 1'b1;
        if (bit_end) state_d = ST_STOP;
      end
      ST_READ: begin
        if (sample) rx_d = {rx_q[6:0], sda_in};
        if (bit_end) begin
          if (bit_cnt_q == 3'd0) state_d = ST_READ_NACK;
          else                   bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      ST_READ_NACK: begin
        if (bit_end) begin
          rdata_d = rx_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // START drops scl at Q3 so the first address bit can change SDA at Q0 without a race.
  always_comb begin
    scl_drv = 1'b1;
    sda_low = 1'b0;
    case (state_q)
      ST_START: begin
        scl_drv = (quarter != Q_LAST);
        sda_low = quarter[1];
      end
      ST_ADDR: begin
        scl_drv = quarter[1];
        sda_low = ~addr_byte[bit_cnt_q];
      end
      ST_WRITE: begin
        scl_drv = quarter[1];
        sda_low = ~wdata_q[bit_cnt_q];
      end
      ST_ADDR_ACK, ST_WRITE_ACK, ST_READ, ST_READ_NACK: begin
        scl_drv = quarter[1];
      end
      ST_STOP: begin
        scl_drv = quarter[1];
        sda_low = (quarter != Q_LAST);
      end
      default: begin
        scl_drv = 1'b1;
        sda_low = 1'b0;
      end
    endcase
  end

  assign scl = scl_drv;
  assign sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rw_q        <= RW_WRITE;
      wdata_q     <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      ack_error_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      ack_error_q <= ack_error_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - directed self-checking bench for i2c_master with a bus-level slave model
module tb_i2c_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] data_write_master = 8'h00;
  logic [7:0] data_read_master;
  logic       busy, done, ack_error;
  wire        scl;
  wire        sda;

`ifdef I2C_MASTER_ACK_CHECK_EN
  localparam int NACK_LAT = 176;
`else
  localparam int NACK_LAT = 320;
`endif

  logic        sl_drv = 1'b0;
  logic        sl_ack = 1'b1;
  logic [7:0]  sl_rd  = 8'h00;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic [31:0] bus_bits = '0;
  int          nbits = 0;
  int          stop_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  assign sda = sl_drv ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_master dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .rw                (rw),
    .data_write_master (data_write_master),
    .data_read_master  (data_read_master),
    .busy              (busy),
    .done              (done),
    .ack_error         (ack_error),
    .scl               (scl),
    .sda               (sda)
  );

  // Slave model: samples the bus on the falling clk edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      sl_drv = 1'b0;
    end else begin
      if (prev_scl && scl && prev_sda && !sda) nbits = 0;
      if (prev_scl && scl && !prev_sda && sda) stop_cnt++;
      if (!prev_scl && scl && nbits < 32) begin
        bus_bits[nbits] = sda;
        nbits++;
      end
      if (prev_scl && !scl) begin
        if (nbits == 8)                                    sl_drv = sl_ack;
        else if (nbits == 17 && !bus_bits[7])              sl_drv = sl_ack;
        else if (nbits >= 9 && nbits <= 16 && bus_bits[7]) sl_drv = !sl_rd[16 - nbits];
        else                                               sl_drv = 1'b0;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bus_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bus_bits[base+i];
    return b;
  endfunction

  task automatic run_txn(input string tag, input logic r, input logic [7:0] wd, input int poke_at,
                         output int lat, output int n_done, output int n_stop);
    int s0;
    s0 = stop_cnt;
    @(negedge clk);
    rw = r;
    data_write_master = wd;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy_on_accept"}, busy, 1);
    lat = 0;
    n_done = 0;
    while (n_done == 0 && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      start = (lat == poke_at - 1);
      if (start) begin
        rw = ~r;
        data_write_master = ~wd;
      end
      if (done) n_done++;
    end
    start = 1'b0;
    chk({tag, "_no_timeout"}, lat < 2000, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    n_stop = stop_cnt - s0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, nd, ns;

    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_error", ack_error, 0);
    chk("rst_rdata", data_read_master, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sl_ack = 1'b1;
    run_txn("wr_a5", 1'b0, 8'hA5, 0, lat, nd, ns);
    chk("wr_a5_latency", lat, 320);
    chk("wr_a5_addr", bus_byte(0), 8'hAA);
    chk("wr_a5_addr_ack", bus_bits[8], 0);
    chk("wr_a5_data", bus_byte(9), 8'hA5);
    chk("wr_a5_ack_error", ack_error, 0);
    chk("wr_a5_done_count", nd, 1);
    chk("wr_a5_stop", ns, 1);

    sl_rd = 8'h3C;
    run_txn("rd_3c", 1'b1, 8'h00, 0, lat, nd, ns);
    chk("rd_3c_latency", lat, 320);
    chk("rd_3c_addr", bus_byte(0), 8'hAB);
    chk("rd_3c_rdata", data_read_master, 8'h3C);
    chk("rd_3c_master_nack", bus_bits[17], 1);
    chk("rd_3c_ack_error", ack_error, 0);
    chk("rd_3c_stop", ns, 1);

    sl_ack = 1'b0;
    run_txn("nack", 1'b0, 8'h5A, 0, lat, nd, ns);
    chk("nack_latency", lat, NACK_LAT);
    chk("nack_addr", bus_byte(0), 8'hAA);
    chk("nack_ack_error", ack_error, 1);
    chk("nack_stop", ns, 1);
    chk("nack_rdata_held", data_read_master, 8'h3C);

    sl_ack = 1'b1;
    run_txn("busy_start", 1'b0, 8'h96, 100, lat, nd, ns);
    chk("busy_start_latency", lat, 320);
    chk("busy_start_done_count", nd, 1);
    chk("busy_start_addr", bus_byte(0), 8'hAA);
    chk("busy_start_data", bus_byte(9), 8'h96);
    chk("busy_start_ack_error", ack_error, 0);

    sl_rd = 8'hC3;
    @(negedge clk);
    rw = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_scl", scl, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rdata", data_read_master, 8'h00);
    @(negedge clk);
    #1;
    chk("abort_sda", sda, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_idle_busy", busy, 0);

    run_txn("wr_0f", 1'b0, 8'h0F, 0, lat, nd, ns);
    chk("wr_0f_latency", lat, 320);
    chk("wr_0f_addr", bus_byte(0), 8'hAA);
    chk("wr_0f_data", bus_byte(9), 8'h0F);
    chk("wr_0f_ack_error", ack_error, 0);
    chk("wr_0f_done_count", nd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
